cursor_ctrl: RTL and testbench

Frame-synchronous cursor and IR-sensor front end for the VGA game display. It converts level button inputs into an accelerating, bounded cursor position that updates once per video frame. It also debounces an N-channel IR receiver bus and flags newly asserted channels. It sits between the board inputs and `vga_controller`, which draws the cursor at (`oX`,`oY`) and uses `oIR_HIT` for scene logic.

---
 rtl/cursor_ctrl_pkg.sv | 18 +
 rtl/cursor_ctrl_ir_debounce.sv | 42 ++++
 rtl/cursor_ctrl.sv | 178 +++++++++++++++++
 tb/tb_cursor_ctrl.sv | 295 +++++++++++++++++++++++++++++
 4 files changed

// File: rtl/cursor_ctrl_pkg.sv
// cursor_pkg: shared types and width helpers for the cursor/IR front end.
package cursor_pkg;

  // Bits needed to encode the three speed states.
  localparam int ST_W = $clog2(3);

  typedef enum logic [ST_W-1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    FAST = 2'd2
  } speed_state_t;

  // Width of a field able to index/count n values; never less than one bit.
  function automatic int width_of(input int n);
    return (n <= 2) ? 1 : $clog2(n);
  endfunction

endpackage

// File: rtl/cursor_ctrl_ir_debounce.sv
// ir_debounce: one IR channel. A raw level that disagrees with the accepted
// level for DEB_CYC consecutive cycles becomes the new accepted level.
// 'rise' flags the cycle in which an accepted 0->1 is about to be registered,
// so the parent can register its event in the same edge as 'hit'.
module ir_debounce
  import cursor_pkg::*;
#(
  parameter int DEB_CYC = 4
) (
  input  logic clk,
  input  logic rst,
  input  logic raw,
  output logic hit,
  output logic rise
);

  localparam int CNT_W = width_of(DEB_CYC + 1);

  logic [CNT_W-1:0] cnt_p1;
  logic             hit_p1;
  logic             accept_p0;

  assign accept_p0 = (raw != hit_p1) && (cnt_p1 == CNT_W'(DEB_CYC - 1));
  assign rise      = accept_p0 && raw;
  assign hit       = hit_p1;

  // Mismatch counter and accepted level; any match restarts the count.
  always_ff @(posedge clk) begin
    if (rst) begin
      cnt_p1 <= '0;
      hit_p1 <= 1'b0;
    end else if (raw == hit_p1) begin
      cnt_p1 <= '0;
    end else if (accept_p0) begin
      cnt_p1 <= '0;
      hit_p1 <= raw;
    end else begin
      cnt_p1 <= cnt_p1 + CNT_W'(1);
    end
  end

endmodule

// File: rtl/cursor_ctrl.sv
// cursor_ctrl: frame-synchronous accelerating cursor plus debounced IR bus.
// Build option: define CURSOR_WRAP_EN to make the cursor wrap at the screen
// edges; by default it clamps at the edges.
module cursor_ctrl
  import cursor_pkg::*;
#(
  parameter int H_RES        = 640,
  parameter int V_RES        = 480,
  parameter int STEP         = 2,
  parameter int MAX_STEP     = 8,
  parameter int ACCEL_FRAMES = 16,
  parameter int N_IR         = 16,
  parameter int DEB_CYC      = 4
) (
  input  logic                     iCLK,
  input  logic                     iRST,
  input  logic                     iFRAME,
  input  logic                     iUP,
  input  logic                     iDOWN,
  input  logic                     iLEFT,
  input  logic                     iRIGHT,
  input  logic [N_IR-1:0]          iIR,
  output logic [$clog2(H_RES)-1:0] oX,
  output logic [$clog2(V_RES)-1:0] oY,
  output logic                     oMOVING,
  output logic [N_IR-1:0]          oIR_HIT,
  output logic                     oIR_EVT,
  output logic [$clog2(N_IR)-1:0]  oIR_IDX
);

  localparam int X_W = $clog2(H_RES);
  localparam int Y_W = $clog2(V_RES);
  localparam int I_W = $clog2(N_IR);
  localparam int P_W = ((X_W > Y_W) ? X_W : Y_W) + 1;
  localparam int S_W = width_of(MAX_STEP + 1);
  localparam int A_W = width_of(ACCEL_FRAMES + 1);

  // One axis step, one bit wider than the coordinate so nothing overflows.
  function automatic logic [P_W-1:0] step_axis(input logic [P_W-1:0] pos,
                                               input logic           inc,
                                               input logic [P_W-1:0] spd,
                                               input logic [P_W-1:0] lim);
    logic [P_W-1:0] res;
    res = pos;
    if (inc) begin
      res = pos + spd;
`ifdef CURSOR_WRAP_EN
      if (res >= lim) res = res - lim;
`else
      if (res >= lim) res = lim - P_W'(1);
`endif
    end else begin
`ifdef CURSOR_WRAP_EN
      if (pos < spd) res = pos + lim - spd;
      else           res = pos - spd;
`else
      if (pos < spd) res = '0;
      else           res = pos - spd;
`endif
    end
    return res;
  endfunction

  // Double the speed, saturating at the ceiling.
  function automatic logic [S_W-1:0] double_speed(input logic [S_W-1:0] spd);
    logic [S_W:0] dbl;
    dbl = {spd, 1'b0};
    if (dbl >= (S_W+1)'(MAX_STEP)) return S_W'(MAX_STEP);
    return dbl[S_W-1:0];
  endfunction

  // Index of the lowest set bit (0 when none set).
  function automatic logic [I_W-1:0] lowest_set(input logic [N_IR-1:0] v);
    logic [I_W-1:0] idx;
    idx = '0;
    for (int i = N_IR - 1; i >= 0; i--) begin
      if (v[i]) idx = I_W'(i);
    end
    return idx;
  endfunction

  speed_state_t     state_p0, state_p1;
  logic [S_W-1:0]   speed_p0, speed_p1;
  logic [A_W-1:0]   held_p0,  held_p1;
  logic [X_W-1:0]   x_p0,     x_p1;
  logic [Y_W-1:0]   y_p0,     y_p1;
  logic             moving_p1;
  logic             h_dir, v_dir;
  logic [A_W-1:0]   held_nx;
  logic [N_IR-1:0]  hit_w, rise_w;
  logic             evt_p1;
  logic [I_W-1:0]   idx_p1;

  // Speed FSM and position update, evaluated only in the frame-pulse cycle.
  always_comb begin
    state_p0 = state_p1;
    speed_p0 = speed_p1;
    held_p0  = held_p1;
    x_p0     = x_p1;
    y_p0     = y_p1;
    h_dir    = iRIGHT ^ iLEFT;
    v_dir    = iDOWN ^ iUP;
    held_nx  = held_p1 + A_W'(1);
    if (iFRAME) begin
      if (!h_dir && !v_dir) begin
        state_p0 = IDLE;
        speed_p0 = S_W'(STEP);
        held_p0  = '0;
      end else begin
        if (h_dir) x_p0 = X_W'(step_axis(P_W'(x_p1), iRIGHT, P_W'(speed_p1), P_W'(H_RES)));
        if (v_dir) y_p0 = Y_W'(step_axis(P_W'(y_p1), iDOWN, P_W'(speed_p1), P_W'(V_RES)));
        if (state_p1 == FAST) begin
          held_p0 = '0;
        end else begin
          if (held_nx == A_W'(ACCEL_FRAMES)) begin
            speed_p0 = double_speed(speed_p1);
            held_p0  = '0;
          end else begin
            held_p0  = held_nx;
          end
          state_p0 = (speed_p0 == S_W'(MAX_STEP)) ? FAST : RUN;
        end
      end
    end
  end

  // ---- stage boundary: cursor state registers ----
  // Cursor state and registered outputs; reset discards any move in flight.
  always_ff @(posedge iCLK) begin
    if (iRST) begin
      state_p1  <= IDLE;
      speed_p1  <= S_W'(STEP);
      held_p1   <= '0;
      x_p1      <= X_W'(H_RES / 2);
      y_p1      <= Y_W'(V_RES / 2);
      moving_p1 <= 1'b0;
    end else begin
      state_p1  <= state_p0;
      speed_p1  <= speed_p0;
      held_p1   <= held_p0;
      x_p1      <= x_p0;
      y_p1      <= y_p0;
      moving_p1 <= (state_p0 != IDLE);
    end
  end

  for (genvar g = 0; g < N_IR; g++) begin : g_ir
    ir_debounce #(
      .DEB_CYC(DEB_CYC)
    ) u_deb (
      .clk (iCLK),
      .rst (iRST),
      .raw (iIR[g]),
      .hit (hit_w[g]),
      .rise(rise_w[g])
    );
  end

  // ---- stage boundary: IR event registers ----
  // Event pulse and lowest riser index, registered with the debounced rise.
  always_ff @(posedge iCLK) begin
    if (iRST) begin
      evt_p1 <= 1'b0;
      idx_p1 <= '0;
    end else begin
      evt_p1 <= |rise_w;
      if (|rise_w) idx_p1 <= lowest_set(rise_w);
    end
  end

  assign oX      = x_p1;
  assign oY      = y_p1;
  assign oMOVING = moving_p1;
  assign oIR_HIT = hit_w;
  assign oIR_EVT = evt_p1;
  assign oIR_IDX = idx_p1;

endmodule

// File: tb/tb_cursor_ctrl.sv
// tb_cursor_ctrl: scoreboard bench for cursor_ctrl (cursor moves and IR bus).
`timescale 1ns/1ps
module tb_cursor_ctrl;

  localparam int H_RES        = 640;
  localparam int V_RES        = 480;
  localparam int STEP         = 2;
  localparam int MAX_STEP     = 8;
  localparam int ACCEL_FRAMES = 16;
  localparam int N_IR         = 16;
  localparam int DEB_CYC      = 4;

  logic            iCLK = 1'b0;
  logic            iRST, iFRAME, iUP, iDOWN, iLEFT, iRIGHT;
  logic [N_IR-1:0] iIR;
  logic [9:0]      oX;
  logic [8:0]      oY;
  logic            oMOVING;
  logic [N_IR-1:0] oIR_HIT;
  logic            oIR_EVT;
  logic [3:0]      oIR_IDX;

  cursor_ctrl #(
    .H_RES(H_RES), .V_RES(V_RES), .STEP(STEP), .MAX_STEP(MAX_STEP),
    .ACCEL_FRAMES(ACCEL_FRAMES), .N_IR(N_IR), .DEB_CYC(DEB_CYC)
  ) dut (
    .iCLK(iCLK), .iRST(iRST), .iFRAME(iFRAME),
    .iUP(iUP), .iDOWN(iDOWN), .iLEFT(iLEFT), .iRIGHT(iRIGHT),
    .iIR(iIR), .oX(oX), .oY(oY), .oMOVING(oMOVING),
    .oIR_HIT(oIR_HIT), .oIR_EVT(oIR_EVT), .oIR_IDX(oIR_IDX)
  );

  always #5 iCLK = ~iCLK;

  typedef struct {
    string tag;
    int    val;
  } exp_t;

  exp_t sb_q[$];
  int   n_total = 0;
  int   n_bad   = 0;

  // reference model state
  int              mx, my, mheld, mmov;
  logic [N_IR-1:0] mhit;
  int              mcnt[N_IR];
  int              midx, mevt;
  int              evt_seen;

  task automatic check_val(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_total++;
    if (obs !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0d want %0d", tag, obs, exp);
    end
  endtask

  task automatic sb_push(input string tag, input int v);
    exp_t e;
    e.tag = tag;
    e.val = v;
    sb_q.push_back(e);
  endtask

  task automatic sb_pop(input logic [31:0] obs);
    exp_t e;
    if (sb_q.size() == 0) begin
      check_val("sb_underflow", 32'd1, 32'd0);
    end else begin
      e = sb_q.pop_front();
      check_val(e.tag, obs, e.val);
    end
  endtask

  function automatic int model_axis(input int pos, input bit inc, input int s, input int lim);
    int r;
`ifdef CURSOR_WRAP_EN
    if (inc) r = (pos + s >= lim) ? pos + s - lim : pos + s;
    else     r = (pos < s) ? pos + lim - s : pos - s;
`else
    if (inc) r = (pos + s > lim - 1) ? lim - 1 : pos + s;
    else     r = (pos - s < 0) ? 0 : pos - s;
`endif
    return r;
  endfunction

  task automatic model_reset();
    mx = H_RES / 2; my = V_RES / 2; mheld = 0; mmov = 0;
    mhit = '0; midx = 0; mevt = 0;
    for (int i = 0; i < N_IR; i++) mcnt[i] = 0;
  endtask

  // One frame pulse with the given buttons; expectation pushed, then checked.
  task automatic do_frame(input bit u, input bit d, input bit l, input bit r);
    bit hd, vd;
    int sh, s;
    @(negedge iCLK);
    iUP = u; iDOWN = d; iLEFT = l; iRIGHT = r; iFRAME = 1'b1;
    hd = r ^ l;
    vd = d ^ u;
    if (!hd && !vd) begin
      mheld = 0;
      mmov  = 0;
    end else begin
      sh = mheld / ACCEL_FRAMES;
      s  = (sh >= 8) ? MAX_STEP : (STEP << sh);
      if (s > MAX_STEP) s = MAX_STEP;
      if (hd) mx = model_axis(mx, r, s, H_RES);
      if (vd) my = model_axis(my, d, s, V_RES);
      mheld++;
      mmov = 1;
    end
    sb_push("x", mx);
    sb_push("y", my);
    sb_push("moving", mmov);
    @(posedge iCLK);
    #1;
    iFRAME = 1'b0;
    sb_pop(oX);
    sb_pop(oY);
    sb_pop(oMOVING);
  endtask

  // One clock with the given raw IR levels, checked against the debounce model.
  task automatic ir_cycle(input logic [N_IR-1:0] v);
    @(negedge iCLK);
    iIR  = v;
    mevt = 0;
    for (int i = 0; i < N_IR; i++) begin
      if (v[i] != mhit[i]) begin
        if (mcnt[i] == DEB_CYC - 1) begin
          mcnt[i] = 0;
          mhit[i] = v[i];
          if (v[i] && mevt == 0) begin
            mevt = 1;
            midx = i;
          end
        end else begin
          mcnt[i]++;
        end
      end else begin
        mcnt[i] = 0;
      end
    end
    sb_push("ir_hit", int'(mhit));
    sb_push("ir_evt", mevt);
    sb_push("ir_idx", midx);
    @(posedge iCLK);
    #1;
    sb_pop(oIR_HIT);
    sb_pop(oIR_EVT);
    sb_pop(oIR_IDX);
    evt_seen += int'(oIR_EVT);
  endtask

  task automatic ir_hold(input logic [N_IR-1:0] v, input int n);
    for (int i = 0; i < n; i++) ir_cycle(v);
  endtask

  // Reset for one cycle, optionally with a right-button frame in the same cycle.
  task automatic reset_dut(input bit with_frame);
    @(negedge iCLK);
    iRST = 1'b1;
    iFRAME = with_frame; iRIGHT = with_frame;
    iUP = 1'b0; iDOWN = 1'b0; iLEFT = 1'b0;
    model_reset();
    sb_push("rst_x", mx);
    sb_push("rst_y", my);
    sb_push("rst_moving", 0);
    @(posedge iCLK);
    #1;
    sb_pop(oX);
    sb_pop(oY);
    sb_pop(oMOVING);
    check_val("rst_ir_hit", oIR_HIT, 0);
    check_val("rst_ir_evt", oIR_EVT, 0);
    check_val("rst_ir_idx", oIR_IDX, 0);
    iRST = 1'b0; iFRAME = 1'b0; iRIGHT = 1'b0; iIR = '0;
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout want finish");
    $fatal(1, "watchdog");
  end

  initial begin
    int first_hit;
    iRST = 1'b0; iFRAME = 1'b0; iUP = 1'b0; iDOWN = 1'b0; iLEFT = 1'b0; iRIGHT = 1'b0;
    iIR = '0;
    evt_seen = 0;
    model_reset();
    repeat (2) @(posedge iCLK);

    reset_dut(1'b0);

    // first press
    do_frame(0, 0, 0, 1);
    check_val("x_first", oX, 322);
    check_val("y_first", oY, 240);
    check_val("mov_first", oMOVING, 1);
    do_frame(0, 0, 0, 0);
    check_val("mov_idle", oMOVING, 0);

    // acceleration profile
    reset_dut(1'b0);
    for (int i = 0; i < 40; i++) begin
      do_frame(0, 0, 0, 1);
      if (i == 15) check_val("x_f16", oX, 352);
      if (i == 31) check_val("x_f32", oX, 416);
      if (i == 39) check_val("x_f40", oX, 480);
    end
    do_frame(0, 0, 0, 0);
    check_val("mov_release", oMOVING, 0);
    do_frame(0, 0, 0, 1);
    check_val("x_repress", oX, 482);

    // buttons without a frame pulse must not move the cursor
    @(negedge iCLK);
    iRIGHT = 1'b0; iLEFT = 1'b1;
    repeat (3) @(posedge iCLK);
    #1;
    check_val("x_no_frame", oX, mx);

    // drive to the left edge, then one more step from x=0
    for (int i = 0; i < 90; i++) do_frame(0, 0, 1, 0);
    check_val("x_at_edge", oX, 0);
    do_frame(0, 0, 0, 0);
    do_frame(0, 0, 1, 0);
`ifdef CURSOR_WRAP_EN
    check_val("x_edge_step", oX, 638);
`else
    check_val("x_edge_step", oX, 0);
`endif

    // opposing vertical buttons cancel
    do_frame(0, 0, 0, 0);
    do_frame(1, 1, 0, 0);
    check_val("y_updown", oY, 240);
    check_val("mov_updown", oMOVING, 0);
    do_frame(1, 1, 0, 1);
    check_val("y_updown_r", oY, 240);

    // diagonal and bottom edge
    for (int i = 0; i < 80; i++) do_frame(0, 1, 0, 1);
    for (int i = 0; i < 3; i++) do_frame(1, 0, 1, 0);

    // IR: short glitch rejected
    evt_seen = 0;
    ir_hold(16'h0020, 3);
    ir_hold(16'h0000, 6);
    check_val("short_evt", evt_seen, 0);
    check_val("short_hit", oIR_HIT[5], 0);

    // IR: real pulse on channel 5
    evt_seen  = 0;
    first_hit = -1;
    for (int c = 0; c < 10; c++) begin
      ir_cycle(16'h0020);
      if (oIR_HIT[5] && first_hit < 0) first_hit = c + 1;
    end
    check_val("hit_latency", first_hit, DEB_CYC);
    check_val("ch5_evt_cnt", evt_seen, 1);
    check_val("ch5_idx", oIR_IDX, 5);
    ir_hold(16'h0000, 6);
    check_val("fall_no_evt", evt_seen, 1);
    check_val("ch5_fall_hit", oIR_HIT[5], 0);
    check_val("idx_held", oIR_IDX, 5);

    // IR: channels 3 and 9 together
    evt_seen = 0;
    ir_hold(16'h0208, 8);
    check_val("dual_evt_cnt", evt_seen, 1);
    check_val("dual_idx", oIR_IDX, 3);
    check_val("dual_hit", oIR_HIT & 16'h0208, 16'h0208);
    ir_hold(16'h0000, 6);

    // reset while running fast with an IR hit set
    reset_dut(1'b0);
    for (int i = 0; i < 40; i++) do_frame(0, 0, 0, 1);
    check_val("mov_fast", oMOVING, 1);
    ir_hold(16'h0080, 6);
    check_val("pre_rst_hit", oIR_HIT[7], 1);
    iIR = 16'h0080;
    reset_dut(1'b1);
    check_val("rst_fast_x", oX, 320);
    check_val("rst_fast_y", oY, 240);

    check_val("sb_drained", sb_q.size(), 0);
    $display("test done: total=%0d bad=%0d", n_total, n_bad);
    $finish;
  end

endmodule
